// File: rtl/aes_pkcs7_unpacker.sv
// aes_pkcs7_unpacker
// Serialises 128-bit decrypted blocks into an LSB-first byte stream and,
// when stripping is enabled, removes PKCS#7 padding from the final block.
// Byte 15 of a non-final block is held back while stripping, because it can
// only be classified once the following block shows whether the packet ends.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | ready for a new block (only state with s_axis_tready=1)
// EVAL    | one cycle to decode padding and compute the byte count n
// HELD    | emitting the byte withheld from the previous non-final block
// SEND    | emitting bytes 0..n-1 of the current block
module aes_pkcs7_unpacker #(
  parameter int BYTES     = 16,
  parameter bit CHECK_ALL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strip_en,
  input  logic [8*BYTES-1:0]   s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 pad_err,
  output logic                 empty_pkt
);

  localparam int W = 8 * BYTES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_HELD,
    ST_SEND
  } state_t;

  state_t       state_q;
  logic [W-1:0] buf_q;
  logic         last_q;
  logic         strip_q;
  logic [7:0]   held_q;
  logic         held_vld_q;
  logic [4:0]   n_q;
  logic [4:0]   idx_q;

  logic [7:0]   pad_p;
  logic         range_ok;
  logic         match_ok;
  logic         pad_bad;
  logic [4:0]   n_d;

  // Decode the pad length held in the top byte and derive the emit count.
  always_comb begin
    pad_p    = buf_q[W-1 -: 8];
    range_ok = (pad_p >= 8'd1) && (pad_p <= 8'd16);
    match_ok = 1'b1;
    if (CHECK_ALL) begin
      for (int i = 0; i < 16; i++) begin
        if (((i + int'(pad_p)) >= 16) && (buf_q[8*i +: 8] != pad_p)) begin
          match_ok = 1'b0;
        end
      end
    end
    pad_bad = 1'b0;
    if (!last_q) begin
      n_d = strip_q ? 5'd15 : 5'd16;
    end else if (!strip_q) begin
      n_d = 5'd16;
    end else if (range_ok && match_ok) begin
      n_d = 5'd16 - pad_p[4:0];
    end else begin
      n_d     = 5'd16;
      pad_bad = 1'b1;
    end
  end

  assign s_axis_tready = (state_q == ST_IDLE) && !rst;
  assign m_axis_tvalid = (state_q == ST_HELD) || (state_q == ST_SEND);
  assign pad_err       = (state_q == ST_EVAL) && pad_bad;
  assign empty_pkt     = (state_q == ST_EVAL) && !held_vld_q && (n_d == 5'd0) && last_q;

  // Output byte and last flag come straight from registered state, so they
  // stay stable for as long as the sink stalls.
  always_comb begin
    m_axis_tdata = 8'h00;
    m_axis_tlast = 1'b0;
    case (state_q)
      ST_HELD: begin
        m_axis_tdata = held_q;
        m_axis_tlast = last_q && (n_q == 5'd0);
      end
      ST_SEND: begin
        m_axis_tdata = buf_q[{idx_q[3:0], 3'b000} +: 8];
        m_axis_tlast = last_q && (idx_q == (n_q - 5'd1));
      end
      default: begin
        m_axis_tdata = 8'h00;
        m_axis_tlast = 1'b0;
      end
    endcase
  end

  // Block capture, held-byte bookkeeping and byte sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      last_q     <= 1'b0;
      strip_q    <= 1'b0;
      held_q     <= 8'h00;
      held_vld_q <= 1'b0;
      n_q        <= 5'd0;
      idx_q      <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= 5'd0;
          if (s_axis_tvalid) begin
            buf_q   <= s_axis_tdata;
            last_q  <= s_axis_tlast;
            strip_q <= strip_en;
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          n_q <= n_d;
          if (held_vld_q) begin
            state_q <= ST_HELD;
          end else if (n_d != 5'd0) begin
            state_q <= ST_SEND;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HELD: begin
          if (m_axis_tready) begin
            held_vld_q <= 1'b0;
            state_q    <= (n_q != 5'd0) ? ST_SEND : ST_IDLE;
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            if (idx_q == (n_q - 5'd1)) begin
              idx_q   <= 5'd0;
              state_q <= ST_IDLE;
              if (!last_q && strip_q) begin
                held_q     <= buf_q[W-1 -: 8];
                held_vld_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_pkcs7_unpacker.sv
// Directed bench for aes_pkcs7_unpacker: byte order, padding strip, held
// byte across blocks, empty packet, bad padding, stalls and mid-send reset.
module tb_aes_pkcs7_unpacker;

  logic         clk = 1'b0;
  logic         rst;
  logic         strip_en;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         pad_err;
  logic         empty_pkt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  int         pad_cnt;
  int         empty_cnt;
  int         acc_c;
  int         first_c;
  logic       accepted;

  localparam logic [127:0] D1   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D2   = 128'h05050505050A09080706050403020100;
  localparam logic [127:0] DPAD = {16{8'h10}};
  localparam logic [127:0] D5   = 128'h000E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D6   = 128'h110E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D7   = 128'h0404040C0B0A09080706050403020100;
  localparam logic [127:0] D8   = 128'h010E0D0C0B0A09080706050403020100;

  aes_pkcs7_unpacker #(.BYTES(16), .CHECK_ALL(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .strip_en      (strip_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pad_err       (pad_err),
    .empty_pkt     (empty_pkt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_data.delete();
    got_last.delete();
    pad_cnt   = 0;
    empty_cnt = 0;
  endtask

  // Offer one block and watch the output for a fixed number of cycles.
  task automatic run(input logic [127:0] d, input logic l, input logic s,
                     input int cyc, input bit rnd);
    logic       pend;
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    strip_en      = s;
    s_axis_tvalid = 1'b1;
    pend       = 1'b0;
    prev_stall = 1'b0;
    prev_d     = 8'h00;
    prev_l     = 1'b0;
    accepted   = 1'b0;
    acc_c      = -1;
    first_c    = -1;
    for (int c = 0; c < cyc; c++) begin
      m_axis_tready = (rnd && ($urandom_range(0, 1) == 0)) ? 1'b0 : 1'b1;
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("stall_data", {24'd0, m_axis_tdata}, {24'd0, prev_d});
        check("stall_last", {31'd0, m_axis_tlast}, {31'd0, prev_l});
      end
      if (s_axis_tvalid && s_axis_tready) begin
        accepted = 1'b1;
        acc_c    = c;
        pend     = 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_data.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
        if (first_c < 0) first_c = c;
      end
      if (pad_err) pad_cnt++;
      if (empty_pkt) empty_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
      @(posedge clk);
      #1;
      if (pend) begin
        s_axis_tvalid = 1'b0;
        pend = 1'b0;
      end
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  // Compare captured bytes against bytes start..start+n-1 of blk.
  task automatic check_out(input string tag, input logic [127:0] blk, input int start,
                           input int n, input bit last_exp);
    check({tag, "_count"}, got_data.size(), n);
    for (int k = 0; k < n && k < got_data.size(); k++) begin
      check($sformatf("%s_byte%0d", tag, k), {24'd0, got_data[k]},
            {24'd0, blk[8*(start+k) +: 8]});
      check($sformatf("%s_last%0d", tag, k), {31'd0, got_last[k]},
            {31'd0, (last_exp && (k == n - 1))});
    end
  endtask

  initial begin
    rst           = 1'b1;
    strip_en      = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_pad_err", {31'd0, pad_err}, 32'd0);
    check("rst_empty", {31'd0, empty_pkt}, 32'd0);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_s_tready", {31'd0, s_axis_tready}, 32'd1);

    // No strip: all 16 bytes, two-cycle latency.
    clear_obs();
    run(D1, 1'b1, 1'b0, 22, 1'b0);
    check("t1_accept", {31'd0, accepted}, 32'd1);
    check_out("t1", D1, 0, 16, 1'b1);
    check("t1_latency", first_c - acc_c, 32'd2);
    check("t1_pad_err", pad_cnt, 32'd0);

    // Strip five pad bytes.
    clear_obs();
    run(D2, 1'b1, 1'b1, 22, 1'b0);
    check_out("t2", D2, 0, 11, 1'b1);
    check("t2_latency", first_c - acc_c, 32'd2);
    check("t2_pad_err", pad_cnt, 32'd0);

    // Non-final block holds back byte 15; full-pad final block releases it.
    clear_obs();
    run(D1, 1'b0, 1'b1, 22, 1'b0);
    check_out("t3a", D1, 0, 15, 1'b0);
    clear_obs();
    run(DPAD, 1'b1, 1'b1, 10, 1'b0);
    check_out("t3b", D1, 15, 1, 1'b1);
    check("t3b_empty", empty_cnt, 32'd0);
    check("t3b_pad_err", pad_cnt, 32'd0);

    // Pure-padding packet with nothing held.
    clear_obs();
    run(DPAD, 1'b1, 1'b1, 10, 1'b0);
    check("t4_count", got_data.size(), 32'd0);
    check("t4_empty", empty_cnt, 32'd1);
    check("t4_pad_err", pad_cnt, 32'd0);

    // Bad padding: p=0, p=0x11, p=4 with a mismatching pad byte.
    clear_obs();
    run(D5, 1'b1, 1'b1, 22, 1'b0);
    check_out("t5", D5, 0, 16, 1'b1);
    check("t5_pad_err", pad_cnt, 32'd1);
    clear_obs();
    run(D6, 1'b1, 1'b1, 22, 1'b0);
    check_out("t6", D6, 0, 16, 1'b1);
    check("t6_pad_err", pad_cnt, 32'd1);
    clear_obs();
    run(D7, 1'b1, 1'b1, 22, 1'b0);
    check_out("t7", D7, 0, 16, 1'b1);
    check("t7_pad_err", pad_cnt, 32'd1);

    // Minimum pad length of one.
    clear_obs();
    run(D8, 1'b1, 1'b1, 22, 1'b0);
    check_out("t8", D8, 0, 15, 1'b1);
    check("t8_pad_err", pad_cnt, 32'd0);

    // Random stalls across a full block.
    clear_obs();
    run(D1, 1'b1, 1'b0, 80, 1'b1);
    check_out("t9", D1, 0, 16, 1'b1);

    // Leave a held byte, start another block under stalls, reset mid-send.
    clear_obs();
    run(D1, 1'b0, 1'b1, 22, 1'b0);
    run(D1, 1'b1, 1'b0, 6, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("mrst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("mrst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    rst = 1'b0;
    #1;
    clear_obs();
    run(D2, 1'b1, 1'b1, 22, 1'b0);
    check_out("t10", D2, 0, 11, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
